ifetch_line_buffer: RTL and testbench
=====================================

// Module: ifetch_line_buffer
// PURPOSE
//   Instruction-fetch responder on the consumer side of the PC register. It takes pc_i,
//   returns the 32-bit instruction at that address and asserts stall_o while it cannot.
//   Holds one line-sized buffer refilled from line-wide instruction memory with a
//   req/ack handshake. Sits between the PC and the IF/ID pipeline register.
// PARAMETERS
//   ADDR_W      32  byte-address width of pc_i and mem_addr_o
//   DATA_W      32  instruction width
//   LINE_WORDS  8   instructions per line, power of two; line = LINE_WORDS*DATA_W = 256 b
// PORTS
//   clk_i         in   1       clock; all state updates on posedge
//   rst_i         in   1       asynchronous reset, active-high
//   start_i       in   1       CPU running; low = block idle, fetch nothing
//   flush_i       in   1       invalidate line buffer
//   pc_i          in   ADDR_W  fetch byte address from PC
//   instr_o       out  DATA_W  instruction at pc_i
//   stall_o       out  1       instr_o not valid this cycle; PC must hold
//   mem_enable_o  out  1       line read request to instruction memory
//   mem_addr_o    out  ADDR_W  line-aligned request address
//   mem_data_i    in   LINE_W  returned line, valid with mem_ack_i
//   mem_ack_i     in   1       one-cycle completion strobe
// BEHAVIOUR
//   Reset (async, rst_i=1): state=IDLE, valid=0, tag=0, data=0, miss_addr=0,
//     mem_enable_o=0, mem_addr_o=0, stall_o=0, instr_o=0. Reset mid-miss aborts the
//     request; any later mem_ack_i is ignored in IDLE.
//   Address split: OFF_W=log2(LINE_WORDS)+2; tag=pc_i[ADDR_W-1:OFF_W];
//     word=pc_i[OFF_W-1:2]; pc_i[1:0] ignored.
//   hit = start_i & valid & (tag==pc_i tag) & state==IDLE.
//   Combinational outputs:
//     start_i=0 -> instr_o=0 (NOP), stall_o=0.
//     hit -> instr_o=data[word]; stall_o=0. Zero-cycle hit latency.
//     otherwise with start_i=1 -> instr_o=0, stall_o=1.
//   FSM:
//     IDLE: start_i & !hit -> miss_addr<={tag,OFF_W'b0}; go REQ.
//     REQ: mem_enable_o=1, mem_addr_o=miss_addr held stable until mem_ack_i.
//       On mem_ack_i: data<=mem_data_i, tag<=miss tag, valid<=1; go FILL.
//     FILL: one cycle, stall_o=1, mem_enable_o=0; go IDLE. Hit is re-evaluated there.
//   Miss penalty = memory latency + 2 cycles; back-to-back requests impossible.
//   pc_i changes during REQ/FILL: the fill completes for miss_addr. IDLE then
//     re-compares, and a new miss issues a new request.
//   flush_i: in IDLE, valid<=0 next edge; if flush_i and a miss coincide, the miss
//     still proceeds. In REQ/FILL it sets a pending flag, the fill data is written,
//     and valid stays 0; the flag clears on return to IDLE.
//   start_i falls during REQ: the request completes and the line is installed;
//     outputs follow the start_i=0 rule.
//   mem_ack_i outside REQ is ignored. Word index wraps within the line, no
//     cross-line fetch.
// STRUCTURE
//   Package ifetch_pkg: state enum {IDLE,REQ,FILL} (2-bit), OFF_W/LINE_W localparams,
//     tag/word extract functions.
//   Sub-module ifetch_line_store: valid/tag/data registers, write port (fill) and
//     read mux (word select + tag compare -> hit). The top holds FSM, miss_addr and
//     flush flag.
// TESTING
//   1 Reset, start_i=1, pc_i=0x0, ack after 3 cycles, line word0=0x00000013 ->
//     stall_o=1 for 5 cycles, mem_addr_o=0x0, then instr_o=0x00000013, stall_o=0.
//   2 After (1), pc_i=0x4..0x1C -> each instr_o correct in same cycle, mem_enable_o
//     never asserted.
//   3 pc_i=0x20 (new line) -> mem_addr_o=0x20 held steady through a 10-cycle ack
//     wait; pc_i=0x24 afterwards hits.
//   4 flush_i pulsed during REQ for 0x40 -> fill completes, then IDLE miss: second
//     request to 0x40.
//   5 rst_i asserted mid-REQ, stray mem_ack_i 2 cycles later -> all outputs 0,
//     valid stays 0, next fetch of 0x0 misses.
//   6 start_i=0 with valid line, pc_i=0x4 -> instr_o=0, stall_o=0, no request.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch line buffer.
package ifetch_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } state_t;

  // Byte-offset width of a line: word index bits plus the two byte-lane bits.
  function automatic int off_width(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int line_width(input int line_words, input int data_w);
    return line_words * data_w;
  endfunction

endpackage

// File: rtl/ifetch_line_store.sv
// Single-line instruction store: valid/tag/data registers, fill write port, word read mux.
module ifetch_line_store
  import ifetch_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int TAG_W      = DEF_ADDR_W - off_width(DEF_LINE_WORDS),
  parameter int WORD_W     = $clog2(DEF_LINE_WORDS),
  parameter int LINE_W     = line_width(DEF_LINE_WORDS, DEF_DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_clr_valid,
  input  logic              i_fill_we,
  input  logic              i_fill_valid,
  input  logic [TAG_W-1:0]  i_fill_tag,
  input  logic [LINE_W-1:0] i_fill_data,
  input  logic [TAG_W-1:0]  i_rd_tag,
  input  logic [WORD_W-1:0] i_rd_word,
  output logic              o_tag_hit,
  output logic [DATA_W-1:0] o_rd_data
);

  logic              r_valid;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_words [LINE_WORDS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      for (int i = 0; i < LINE_WORDS; i++) r_words[i] <= '0;
    end else if (i_fill_we) begin
      // A fill always lands its data; validity is decided by the caller.
      r_valid <= i_fill_valid;
      r_tag   <= i_fill_tag;
      for (int i = 0; i < LINE_WORDS; i++) r_words[i] <= i_fill_data[i*DATA_W +: DATA_W];
    end else if (i_clr_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign o_tag_hit = r_valid & (r_tag == i_rd_tag);
  assign o_rd_data = r_words[i_rd_word];

endmodule

// File: rtl/ifetch_line_buffer.sv
// Instruction-fetch responder: zero-latency hits from one line buffer, refilled over req/ack.
// Memory handshake: mem_enable_o/mem_addr_o stay asserted and stable from the first REQ
// cycle until the cycle mem_ack_i is high; mem_ack_i is a one-cycle strobe that also
// qualifies mem_data_i, and is ignored in any state other than REQ.
module ifetch_line_buffer
  import ifetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int OFF_W     = off_width(LINE_WORDS),
  localparam int LINE_W    = line_width(LINE_WORDS, DATA_W),
  localparam int TAG_W     = ADDR_W - OFF_W,
  localparam int WORD_W    = OFF_W - 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              stall_o,
  output logic              mem_enable_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        dbg_state_o
);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_miss_addr;
  logic                r_flush_pend;
  logic [TAG_W-1:0]    w_pc_tag;
  logic [WORD_W-1:0]   w_pc_word;
  logic                w_tag_hit;
  logic                w_hit;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_fill_we;
  logic                w_fill_valid;
  logic                w_clr_valid;
  logic                w_unused_pc_lsb;

  assign w_pc_tag        = pc_i[ADDR_W-1:OFF_W];
  assign w_pc_word       = pc_i[OFF_W-1:2];
  assign w_unused_pc_lsb = ^pc_i[1:0];

  ifetch_line_store #(
    .DATA_W    (DATA_W),
    .LINE_WORDS(LINE_WORDS),
    .TAG_W     (TAG_W),
    .WORD_W    (WORD_W),
    .LINE_W    (LINE_W)
  ) u_store (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_clr_valid (w_clr_valid),
    .i_fill_we   (w_fill_we),
    .i_fill_valid(w_fill_valid),
    .i_fill_tag  (r_miss_addr[ADDR_W-1:OFF_W]),
    .i_fill_data (mem_data_i),
    .i_rd_tag    (w_pc_tag),
    .i_rd_word   (w_pc_word),
    .o_tag_hit   (w_tag_hit),
    .o_rd_data   (w_rd_data)
  );

  assign w_hit = start_i & w_tag_hit & (r_state == S_IDLE);

  always_comb begin
    w_next       = r_state;
    w_fill_we    = 1'b0;
    w_fill_valid = 1'b0;
    w_clr_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clr_valid = flush_i;
        if (start_i && !w_hit) w_next = S_REQ;
      end
      S_REQ: begin
        if (mem_ack_i) begin
          w_fill_we    = 1'b1;
          // A flush seen at any point of the miss leaves the fresh line invalid.
          w_fill_valid = ~(r_flush_pend | flush_i);
          w_next       = S_FILL;
        end
      end
      S_FILL: begin
        w_clr_valid = flush_i;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_miss_addr  <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_REQ) r_miss_addr <= {w_pc_tag, {OFF_W{1'b0}}};
      if (r_state == S_FILL) r_flush_pend <= 1'b0;
      else if (r_state == S_REQ && flush_i) r_flush_pend <= 1'b1;
    end
  end

  assign mem_enable_o = (r_state == S_REQ);
  assign mem_addr_o   = (r_state == S_REQ) ? r_miss_addr : '0;
  assign stall_o      = start_i & ~w_hit;
  assign instr_o      = w_hit ? w_rd_data : '0;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Self-checking bench for ifetch_line_buffer: memory responder plus a line-level fetch model.
module tb_ifetch_line_buffer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         flush_i;
  logic [31:0]  pc_i;
  logic [31:0]  instr_o;
  logic         stall_o;
  logic         mem_enable_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [1:0]   dbg_state_o;

  int checks = 0;
  int errors = 0;

  ifetch_line_buffer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .flush_i     (flush_i),
    .pc_i        (pc_i),
    .instr_o     (instr_o),
    .stall_o     (stall_o),
    .mem_enable_o(mem_enable_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [31:0] mem_words [logic [29:0]];
  logic [31:0] req_log [$];
  logic [31:0] first_addr;
  logic        in_req   = 1'b0;
  int          req_cnt  = 0;
  int          mem_lat  = 1;
  logic        mem_auto = 1'b1;
  int          addr_bad = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [29:0] k;
    k = a[31:2];
    if (!mem_words.exists(k)) mem_words[k] = $urandom;
    return mem_words[k];
  endfunction

  always @(negedge clk_i) begin
    if (mem_enable_o) begin
      if (!in_req) begin
        req_log.push_back(mem_addr_o);
        first_addr = mem_addr_o;
        in_req     = 1'b1;
        req_cnt    = 0;
      end else if (mem_addr_o !== first_addr) begin
        addr_bad++;
      end
      req_cnt++;
      if (mem_auto) begin
        mem_ack_i = (req_cnt == mem_lat);
        if (mem_ack_i)
          for (int i = 0; i < 8; i++) mem_data_i[i*32 +: 32] = word_at(first_addr + 32'(i * 4));
      end
    end else begin
      in_req = 1'b0;
      if (mem_auto) mem_ack_i = 1'b0;
    end
  end

  // ---------------- reference model: one line, hit/miss by line address ----------------
  logic        m_valid = 1'b0;
  logic [26:0] m_line  = '0;

  // One fetch at pc: expects hit latency 0, or (lat+2) per miss; a flush landing inside
  // REQ/FILL forces a second identical miss.
  task automatic do_fetch(input logic [31:0] pc, input int lat, input int flush_at);
    logic        exp_hit;
    int          exp_stall;
    int          exp_reqs;
    int          n;
    int          req_before;
    logic [31:0] exp_instr;
    exp_hit   = m_valid && (pc[31:5] == m_line);
    exp_stall = exp_hit ? 0 : lat + 2;
    exp_reqs  = exp_hit ? 0 : 1;
    if (!exp_hit && flush_at >= 1 && flush_at <= lat + 1) begin
      exp_stall = 2 * (lat + 2);
      exp_reqs  = 2;
    end
    exp_instr  = word_at(pc);
    mem_lat    = lat;
    req_before = req_log.size();
    pc_i       = pc;
    start_i    = 1'b1;
    n          = 0;
    forever begin
      flush_i = (n == flush_at);
      @(negedge clk_i);
      if (!stall_o || n >= 400) break;
      n++;
      @(posedge clk_i); #1;
    end
    checks++;
    if (n !== exp_stall) begin
      errors++;
      $display("FAIL stall_cycles pc=%h got %0d exp %0d", pc, n, exp_stall);
    end
    checks++;
    if (instr_o !== exp_instr) begin
      errors++;
      $display("FAIL instr pc=%h got %h exp %h", pc, instr_o, exp_instr);
    end
    checks++;
    if (req_log.size() - req_before !== exp_reqs) begin
      errors++;
      $display("FAIL req_count pc=%h got %0d exp %0d", pc, req_log.size() - req_before, exp_reqs);
    end
    for (int k = req_before; k < req_log.size(); k++) begin
      checks++;
      if (req_log[k] !== {pc[31:5], 5'b0}) begin
        errors++;
        $display("FAIL req_addr pc=%h got %h exp %h", pc, req_log[k], {pc[31:5], 5'b0});
      end
    end
    m_line  = pc[31:5];
    m_valid = exp_hit ? (flush_at != 0) : 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (instr_o !== 32'h0 || stall_o !== 1'b0 || mem_enable_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL %s got instr=%h stall=%b en=%b addr=%h exp all zero",
               name, instr_o, stall_o, mem_enable_o, mem_addr_o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; pc_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_quiet("reset_outputs");
    checks++;
    if (dbg_state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got %0d exp 0", dbg_state_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_first_miss();
    mem_words[30'h0] = 32'h0000_0013;
    do_fetch(32'h0, 3, -1);
    checks++;
    if (instr_o !== 32'h0000_0013) begin
      errors++;
      $display("FAIL first_instr got %h exp 00000013", instr_o);
    end
  endtask

  task automatic test_line_hits();
    for (int i = 1; i < 8; i++) do_fetch(32'(i * 4) | 32'($urandom_range(0, 3)), 1, -1);
  endtask

  task automatic test_long_wait();
    int bad_before;
    bad_before = addr_bad;
    do_fetch(32'h20, 10, -1);
    checks++;
    if (addr_bad !== bad_before) begin
      errors++;
      $display("FAIL addr_stable got %0d changes exp 0", addr_bad - bad_before);
    end
    do_fetch(32'h24, 10, -1);
  endtask

  task automatic test_flush_in_req();
    do_fetch(32'h40, 4, 2);
    do_fetch(32'h44, 4, -1);
  endtask

  task automatic test_reset_mid_req();
    mem_auto = 1'b0;
    mem_ack_i = 1'b0;
    pc_i = 32'h60; start_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    checks++;
    if (mem_enable_o !== 1'b1) begin
      errors++;
      $display("FAIL req_before_reset got %b exp 1", mem_enable_o);
    end
    rst_i = 1'b1; start_i = 1'b0;
    #1;
    check_quiet("reset_mid_req");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    mem_data_i = '1; mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    check_quiet("stray_ack");
    checks++;
    if (dbg_state_o !== 2'd0) begin
      errors++;
      $display("FAIL stray_ack_state got %0d exp 0", dbg_state_o);
    end
    m_valid = 1'b0;
    mem_auto = 1'b1;
    do_fetch(32'h0, 2, -1);
  endtask

  task automatic test_start_drop();
    int req_before;
    req_before = req_log.size();
    mem_lat = 3;
    pc_i = 32'h80; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      checks++;
      if (instr_o !== 32'h0 || stall_o !== 1'b0) begin
        errors++;
        $display("FAIL start_drop_out cyc=%0d got instr=%h stall=%b exp 0/0", i, instr_o, stall_o);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (req_log.size() - req_before !== 1 || mem_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL start_drop_req got %0d reqs en=%b exp 1 reqs en=0",
               req_log.size() - req_before, mem_enable_o);
    end
    m_valid = 1'b1; m_line = 27'h4;
    do_fetch(32'h84, 3, -1);
  endtask

  task automatic test_random();
    logic [31:0] bases [4];
    logic [31:0] pc;
    for (int i = 0; i < 4; i++) bases[i] = $urandom & 32'hFFFF_FFE0;
    for (int it = 0; it < 40; it++) begin
      pc = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
      do_fetch(pc, int'($urandom_range(1, 6)), ($urandom_range(0, 5) == 0) ? 0 : -1);
    end
  endtask

  task automatic test_start_low();
    do_fetch(32'h0, 2, -1);
    start_i = 1'b0; pc_i = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_quiet("start_low");
      @(posedge clk_i); #1;
    end
    do_fetch(32'h4, 2, -1);
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_line_hits();
    test_long_wait();
    test_flush_in_req();
    test_reset_mid_req();
    test_start_drop();
    test_random();
    test_start_low();
    checks++;
    if (addr_bad !== 0) begin
      errors++;
      $display("FAIL addr_stable_total got %0d exp 0", addr_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
